pr_free_list: RTL and testbench
===============================

Name: pr_free_list

Overview:
- Banked free list of physical registers (PRs).
- Receives PRs freed by the ROB PR free queue at the enqueue end, and hands free PRs to rename at the dequeue end.
- One circular FIFO per PRF bank. A PR enqueued to bank b returns to bank b, so bank balance is preserved.
- Sits between the ROB free path and rename. It also gives per-bank low-water indications to rename for stall and bank steering.

Parameters:
- PR_COUNT, 128, total physical registers.
- PRF_BANK_COUNT, 4, banks; one enqueue port and one dequeue port per bank.
- AR6_COUNT, 64, PRs 0..AR6_COUNT-1 are architecturally mapped at reset and are not free.
- FREE_LIST_LENGTH_PER_BANK, PR_COUNT/PRF_BANK_COUNT = 32, FIFO depth per bank.
- FREE_LIST_LOWER_THRESHOLD, 8, a bank is "low" when its count is below this value.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- enq_valid  in  [BANK_COUNT]  freed PR present for bank b.
- enq_PR  in  [BANK_COUNT][LOG_PR_COUNT]  freed PR for bank b; the low bits must equal b.
- deq_valid  out  [BANK_COUNT]  bank b has a free PR.
- deq_PR  out  [BANK_COUNT][LOG_PR_COUNT]  head PR of bank b, as {upper, b}.
- deq_ready  in  [BANK_COUNT]  rename consumes bank b's head this cycle.
- bank_count  out  [BANK_COUNT][LOG_LEN+1]  per-bank free count.
- bank_low  out  [BANK_COUNT]  bank_count < FREE_LIST_LOWER_THRESHOLD.
- enq_overflow_err  out  1  sticky error: enqueue attempted to a full bank.
- enq_bank_err  out  1  sticky error: enq_PR bank bits differ from the port index.

Behaviour:
- Clocking and reset: one clock, CLK; reset is synchronous and active-high, RST.
- Per-bank state:
  - storage of 32 x upper_PR_t;
  - head and tail pointers, 5 bits each, wrapping naturally modulo 32;
  - count, 6 bits.
- Reset state, per bank b:
  - entries 0..15 hold upper = 16..31, i.e. PRs 64..127 with low bits b;
  - head=0, tail=16, count=16;
  - deq_valid all 1, deq_PR[b] = {5'd16, b}, bank_count = 16, bank_low = 0;
  - both error flags 0.
- Reset while operating: all in-flight enq/deq that cycle are discarded and the reset state loads.
- Dequeue:
  - deq_valid[b] = (count != 0); deq_PR[b] = {mem[head], b}. Both are driven combinationally from registers, with zero latency.
  - Consumption occurs only when deq_valid & deq_ready; head then advances by 1.
  - deq_ready while empty is ignored.
- Enqueue:
  - when enq_valid and count != 32, write upper_PR_bits(enq_PR) to mem[tail] and advance tail by 1;
  - the bank bits are not stored.
- Full bank: an enqueue is dropped and enq_overflow_err is set (sticky until RST). This cannot happen in legal operation.
- Bank mismatch: when enq_PR bank bits != b, the entry is still stored under bank b and enq_bank_err is set (sticky).
- Count update: count_next = count + enq_accepted - deq_accepted.
- Simultaneous enq and deq, bank non-empty: both are accepted and count is unchanged.
- Simultaneous enq and deq, bank empty: no bypass.
  - deq_valid is 0 that cycle.
  - The enqueued PR becomes deq_PR on the next cycle, with count 1.
- Wrap-around: pointers roll 31 -> 0 without a bubble.
- Banks are fully independent; there is no cross-bank stealing.
- bank_count and bank_low derive from the registered count, so they reflect updates one cycle after the accepting edge.

Decomposition:
- Shared package (core_types) holds:
  - PR_COUNT, PRF_BANK_COUNT, FREE_LIST_LENGTH_PER_BANK and its log, FREE_LIST_LOWER_THRESHOLD;
  - PR_t, upper_PR_t, PR_bank_t;
  - the upper_PR_bits and PR_bank_bits functions.
- One natural sub-module: pr_free_list_bank, a single-bank FIFO parameterized by bank index and reset fill.
  - The top instantiates it PRF_BANK_COUNT times and ORs the error flags.

Test Plan:
- Reset, then hold deq_ready=4'b0001 for 16 cycles -> bank 0 yields PRs 64,68,...,124 in order. Cycle 17: deq_valid[0]=0 and bank_count[0]=0. Banks 1-3 stay at count 16.
- Bank 1 empty; enq PR 9 and deq_ready[1]=1 in the same cycle -> deq_valid[1]=0 that cycle. Next cycle deq_PR[1]=9 and count=1.
- Bank 2 at count 10, simultaneous enq PR 6 and deq -> count stays 10. PR 6 appears after the 10 older entries.
- Bank 3: enqueue 16 further PRs to reach 32, then enq PR 7 -> entry dropped, enq_overflow_err=1, count stays 32. Drain 32 -> order shows tail wrap 31->0 with no bubble.
- Enq on port 0 with PR 5 (bank bits 1) -> enq_bank_err=1; the entry is stored in bank 0 and later dequeued as PR 4.
- Drain bank 0 to count 8 -> bank_low[0]=0. One more dequeue -> bank_low[0]=1 next cycle. Assert RST mid-stream -> count 16, deq_PR[0]=64, and errors cleared.

Source files
------------

// File: rtl/pr_free_list_pkg.sv
// Shared core types for the physical register free list.
// PR numbering, bank split and free-list sizing.
package core_types;

  localparam int PR_COUNT = 128;
  localparam int PRF_BANK_COUNT = 4;
  localparam int AR6_COUNT = 64;

  localparam int LOG_PR_COUNT = $clog2(PR_COUNT);
  localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);

  localparam int FREE_LIST_LENGTH_PER_BANK =
    PR_COUNT / PRF_BANK_COUNT;
  localparam int LOG_FREE_LIST_LENGTH_PER_BANK =
    $clog2(FREE_LIST_LENGTH_PER_BANK);
  localparam int FREE_LIST_LOWER_THRESHOLD = 8;

  localparam int UPPER_PR_WIDTH =
    LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

  typedef logic [LOG_PR_COUNT-1:0] PR_t;
  typedef logic [UPPER_PR_WIDTH-1:0] upper_PR_t;
  typedef logic [LOG_PRF_BANK_COUNT-1:0] PR_bank_t;

  typedef logic [LOG_FREE_LIST_LENGTH_PER_BANK-1:0] fl_ptr_t;
  typedef logic [LOG_FREE_LIST_LENGTH_PER_BANK:0] fl_count_t;

  function automatic upper_PR_t upper_PR_bits(input PR_t pr);
    return pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
  endfunction

  function automatic PR_bank_t PR_bank_bits(input PR_t pr);
    return pr[LOG_PRF_BANK_COUNT-1:0];
  endfunction

endpackage

// File: rtl/pr_free_list_if.sv
// Free-list bus: ROB free path and rename on one side,
// banked free list on the other.
interface pr_free_list_if;
  import core_types::*;

  logic [PRF_BANK_COUNT-1:0] enq_valid;
  PR_t [PRF_BANK_COUNT-1:0] enq_PR;

  logic [PRF_BANK_COUNT-1:0] deq_valid;
  PR_t [PRF_BANK_COUNT-1:0] deq_PR;
  logic [PRF_BANK_COUNT-1:0] deq_ready;

  fl_count_t [PRF_BANK_COUNT-1:0] bank_count;
  logic [PRF_BANK_COUNT-1:0] bank_low;

  logic enq_overflow_err;
  logic enq_bank_err;

  modport master (
    output enq_valid,
    output enq_PR,
    output deq_ready,
    input deq_valid,
    input deq_PR,
    input bank_count,
    input bank_low,
    input enq_overflow_err,
    input enq_bank_err
  );

  modport slave (
    input enq_valid,
    input enq_PR,
    input deq_ready,
    output deq_valid,
    output deq_PR,
    output bank_count,
    output bank_low,
    output enq_overflow_err,
    output enq_bank_err
  );

endinterface

// File: rtl/pr_free_list_bank.sv
// One bank of the free list: circular FIFO of upper PR bits.
// Bank bits are implied by BANK and never stored.
module pr_free_list_bank
  import core_types::*;
#(
  parameter int BANK = 0,
  parameter int RESET_BASE = 16,
  parameter int RESET_FILL = 16
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      enq_valid,
  input  PR_t       enq_PR,
  output logic      deq_valid,
  output PR_t       deq_PR,
  input  logic      deq_ready,
  output fl_count_t count,
  output logic      low,
  output logic      overflow_err,
  output logic      bank_err
);

  localparam int LEN = FREE_LIST_LENGTH_PER_BANK;
  localparam PR_bank_t BANK_BITS = PR_bank_t'(BANK);

  upper_PR_t mem [LEN];
  fl_ptr_t   head;
  fl_ptr_t   tail;

  logic full;
  logic enq_acc;
  logic deq_acc;

  assign full = (count == fl_count_t'(LEN));
  assign deq_valid = (count != '0);
  assign deq_PR = {mem[head], BANK_BITS};
  assign low =
    (count < fl_count_t'(FREE_LIST_LOWER_THRESHOLD));

  // empty bank: deq_valid is low, so no same-cycle bypass
  assign enq_acc = enq_valid & ~full;
  assign deq_acc = deq_valid & deq_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LEN; i++) begin
        mem[i] <= (i < RESET_FILL) ?
          upper_PR_t'(RESET_BASE + i) : '0;
      end
      head <= '0;
      tail <= fl_ptr_t'(RESET_FILL);
      count <= fl_count_t'(RESET_FILL);
      overflow_err <= 1'b0;
      bank_err <= 1'b0;
    end else begin
      if (enq_acc) begin
        mem[tail] <= upper_PR_bits(enq_PR);
        tail <= tail + 1'b1;
      end
      if (deq_acc) begin
        head <= head + 1'b1;
      end
      count <= count
        + fl_count_t'(enq_acc)
        - fl_count_t'(deq_acc);
      if (enq_valid && full) begin
        overflow_err <= 1'b1;
      end
      if (enq_valid &&
          PR_bank_bits(enq_PR) != BANK_BITS) begin
        bank_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pr_free_list.sv
// Banked PR free list: one FIFO per PRF bank,
// freed PRs return to their own bank.
module pr_free_list
  import core_types::*;
(
  input logic CLK,
  input logic RST,
  pr_free_list_if.slave fl
);

  // PRs below AR6_COUNT are architecturally mapped at reset
  localparam int RESET_BASE = AR6_COUNT / PRF_BANK_COUNT;
  localparam int RESET_FILL =
    FREE_LIST_LENGTH_PER_BANK - RESET_BASE;

  logic [PRF_BANK_COUNT-1:0] overflow_err;
  logic [PRF_BANK_COUNT-1:0] bank_err;

  for (genvar b = 0; b < PRF_BANK_COUNT; b++) begin : g_bank
    pr_free_list_bank #(
      .BANK(b),
      .RESET_BASE(RESET_BASE),
      .RESET_FILL(RESET_FILL)
    ) u_bank (
      .clk(CLK),
      .rst(RST),
      .enq_valid(fl.enq_valid[b]),
      .enq_PR(fl.enq_PR[b]),
      .deq_valid(fl.deq_valid[b]),
      .deq_PR(fl.deq_PR[b]),
      .deq_ready(fl.deq_ready[b]),
      .count(fl.bank_count[b]),
      .low(fl.bank_low[b]),
      .overflow_err(overflow_err[b]),
      .bank_err(bank_err[b])
    );
  end

  assign fl.enq_overflow_err = |overflow_err;
  assign fl.enq_bank_err = |bank_err;

endmodule

// File: tb/tb_pr_free_list.sv
// Bench for pr_free_list: directed scenarios plus random
// traffic checked against per-bank queue model.
module tb_pr_free_list;
  import core_types::*;

  logic CLK;
  logic RST;

  pr_free_list_if fl();

  pr_free_list dut (
    .CLK(CLK),
    .RST(RST),
    .fl(fl)
  );

  int checks;
  int failures;

  int mq [4][$];
  logic m_ovf;
  logic m_berr;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      mq[b].delete();
      for (int i = 0; i < 16; i++) begin
        mq[b].push_back(64 + 4 * i + b);
      end
    end
    m_ovf = 1'b0;
    m_berr = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] ev,
                            input logic [3:0][6:0] pr,
                            input logic [3:0] rdy);
    for (int b = 0; b < 4; b++) begin
      int n;
      bit eacc;
      bit dacc;
      n = mq[b].size();
      dacc = rdy[b] && n > 0;
      eacc = ev[b] && n < 32;
      if (ev[b] && n == 32) m_ovf = 1'b1;
      if (ev[b] && int'(pr[b][1:0]) != b) m_berr = 1'b1;
      if (dacc) void'(mq[b].pop_front());
      if (eacc) mq[b].push_back((int'(pr[b]) & 'h7c) | b);
    end
  endtask

  task automatic check_all();
    for (int b = 0; b < 4; b++) begin
      int n;
      n = mq[b].size();
      chk($sformatf("deq_valid[%0d]", b),
          32'(fl.deq_valid[b]), 32'(n != 0));
      if (n != 0) begin
        chk($sformatf("deq_PR[%0d]", b),
            32'(fl.deq_PR[b]), 32'(mq[b][0]));
      end
      chk($sformatf("bank_count[%0d]", b),
          32'(fl.bank_count[b]), 32'(n));
      chk($sformatf("bank_low[%0d]", b),
          32'(fl.bank_low[b]), 32'(n < 8));
    end
    chk("enq_overflow_err",
        32'(fl.enq_overflow_err), 32'(m_ovf));
    chk("enq_bank_err", 32'(fl.enq_bank_err), 32'(m_berr));
  endtask

  task automatic cyc(input logic r,
                     input logic [3:0] ev,
                     input logic [3:0][6:0] pr,
                     input logic [3:0] rdy);
    RST = r;
    fl.enq_valid = ev;
    fl.enq_PR = pr;
    fl.deq_ready = rdy;
    @(posedge CLK);
    if (r) model_reset();
    else model_step(ev, pr, rdy);
    @(negedge CLK);
    check_all();
  endtask

  task automatic deq(input logic [3:0] rdy, input int n);
    repeat (n) cyc(1'b0, 4'b0, '0, rdy);
  endtask

  task automatic enq1(input int b, input int pr,
                      input logic [3:0] rdy);
    logic [3:0] ev;
    logic [3:0][6:0] prv;
    ev = '0;
    prv = '0;
    ev[b] = 1'b1;
    prv[b] = 7'(pr);
    cyc(1'b0, ev, prv, rdy);
  endtask

  initial begin
    logic [3:0] ev;
    logic [3:0] rdy;
    logic [3:0][6:0] prv;
    checks = 0;
    failures = 0;
    RST = 1'b1;
    fl.enq_valid = '0;
    fl.enq_PR = '0;
    fl.deq_ready = '0;

    cyc(1'b1, 4'b0, '0, 4'b0);
    chk("rst_pr0", 32'(fl.deq_PR[0]), 64);
    chk("rst_pr3", 32'(fl.deq_PR[3]), 67);

    // bank 0 drains 64,68,...,124
    deq(4'b0001, 16);
    chk("b0_empty", 32'(fl.deq_valid[0]), 0);
    chk("b0_cnt0", 32'(fl.bank_count[0]), 0);
    chk("b1_cnt16", 32'(fl.bank_count[1]), 16);

    // empty bank: enq and deq same cycle, no bypass
    deq(4'b0010, 16);
    chk("b1_empty", 32'(fl.deq_valid[1]), 0);
    enq1(1, 9, 4'b0010);
    chk("b1_pr9", 32'(fl.deq_PR[1]), 9);
    chk("b1_cnt1", 32'(fl.bank_count[1]), 1);

    deq(4'b0100, 6);
    enq1(2, 6, 4'b0100);
    chk("b2_cnt10", 32'(fl.bank_count[2]), 10);
    deq(4'b0100, 9);
    chk("b2_last6", 32'(fl.deq_PR[2]), 6);
    deq(4'b0100, 1);

    // fill bank 3, overflow, drain across the wrap
    for (int i = 0; i < 16; i++) begin
      enq1(3, 4 * $urandom_range(0, 31) + 3, 4'b0);
    end
    chk("b3_full", 32'(fl.bank_count[3]), 32);
    enq1(3, 7, 4'b0);
    chk("ovf_err", 32'(fl.enq_overflow_err), 1);
    chk("b3_cnt32", 32'(fl.bank_count[3]), 32);
    deq(4'b1000, 32);
    chk("b3_empty", 32'(fl.deq_valid[3]), 0);

    enq1(0, 5, 4'b0);
    chk("bank_err", 32'(fl.enq_bank_err), 1);
    chk("b0_pr4", 32'(fl.deq_PR[0]), 4);
    deq(4'b0001, 1);

    cyc(1'b1, 4'b0, '0, 4'b0);
    deq(4'b0001, 8);
    chk("b0_cnt8_low", 32'(fl.bank_low[0]), 0);
    deq(4'b0001, 1);
    chk("b0_cnt7_low", 32'(fl.bank_low[0]), 1);

    for (int k = 0; k < 600; k++) begin
      for (int b = 0; b < 4; b++) begin
        ev[b] = 1'($urandom_range(0, 1));
        rdy[b] = 1'($urandom_range(0, 1));
        prv[b] = {5'($urandom), 2'(b)};
        if ($urandom_range(0, 63) == 0) prv[b][1:0] = 2'($urandom);
      end
      cyc($urandom_range(0, 149) == 0, ev, prv, rdy);
    end

    // reset while traffic is active
    for (int b = 0; b < 4; b++) prv[b] = {5'($urandom), 2'(b)};
    cyc(1'b1, 4'hf, prv, 4'hf);
    chk("rst_cnt16", 32'(fl.bank_count[0]), 16);
    chk("rst_pr64", 32'(fl.deq_PR[0]), 64);
    chk("rst_ovf", 32'(fl.enq_overflow_err), 0);
    chk("rst_berr", 32'(fl.enq_bank_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
